// File: rtl/stream_pkg.sv
// Shared types and helpers for the nibble stream pack/unpack path.
// Latency: none (types, constants and a combinational helper only).
// Backpressure: n/a.
package stream_pkg;

  typedef enum logic {COLLECT, HOLD} unpack_state_t;

  localparam int DEF_DATA_W  = 4;
  localparam int DEF_SLICE_W = 2;

  // Widest word rot_undo can handle; callers zero-extend narrower words.
  localparam int ROT_MAX_W = 64;
  localparam int ROT_IDX_W = 6;

  // Undo a rotation on the low w bits of word.
  // dir = 0 undoes a left rotate (rotate right), dir = 1 undoes a right
  // rotate (rotate left). The amount is taken mod w, so 0 and w both pass.
  function automatic logic [ROT_MAX_W-1:0] rot_undo(
    input logic [ROT_MAX_W-1:0] word,
    input int unsigned          amt,
    input logic                 dir,
    input int unsigned          w
  );
    logic [ROT_MAX_W-1:0] res;
    int unsigned          a;
    int unsigned          src;
    res = '0;
    a   = amt % w;
    for (int unsigned i = 0; i < ROT_MAX_W; i++) begin
      if (i < w) begin
        src = dir ? ((i + w - a) % w) : ((i + a) % w);
        res[i[ROT_IDX_W-1:0]] = word[src[ROT_IDX_W-1:0]];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Output holding register for the unpacker: one word plus its short flag.
// Latency: word visible the cycle after load; leaves on out_valid && out_ready.
// Backpressure: holds data stable while out_ready is low; the caller only
// loads when the register is empty or being drained the same cycle.
//
// Ports:
//   clk, rst            clock and async active-high reset
//   load                a completed word is presented this cycle
//   load_data/short     the completed word and its short flag
//   out_valid/ready     downstream handshake
//   out_data/short      held word and short flag
module stream_out_reg
  import stream_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_short,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_short
);

  unpack_state_t state;
  unpack_state_t state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: begin
        if (load) state_nxt = HOLD;
      end
      HOLD: begin
        // A load here always coincides with the held word leaving.
        if (load)           state_nxt = HOLD;
        else if (out_ready) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  assign out_valid = (state == HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_short <= 1'b0;
    end else if (load) begin
      out_data  <= load_data;
      out_short <= load_short;
    end
  end

endmodule

// File: rtl/stream_unpacker.sv
// Reassembles SLICE_W-bit chunks into DATA_W-bit words, optionally reversing
// slice order and undoing a rotation. Latency: word valid one cycle after the
// completing chunk. Backpressure: only a completing chunk stalls, and only
// while the held output word is not being taken.
//
// Ports:
//   clk, rst                          clock and async active-high reset
//   in_valid/in_ready/in_data/in_last chunk input; in_last ends a word early
//   cfg_rev/cfg_rot/cfg_dir           per-word config, sampled on chunk 0
//   out_valid/out_ready/out_data      word output
//   out_short                         word ended by in_last, missing slices zero
module stream_unpacker
  import stream_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int SLICE_W = DEF_SLICE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SLICE_W-1:0] in_data,
  input  logic              in_last,
  input  logic              cfg_rev,
  input  logic [((DATA_W > 1) ? $clog2(DATA_W) : 1)-1:0] cfg_rot,
  input  logic              cfg_dir,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_short
);

  localparam int NCH   = DATA_W / SLICE_W;
  localparam int ROT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int CNT_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCH - 1);

  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] asm_q;
  logic              cap_rev;
  logic [ROT_W-1:0]  cap_rot;
  logic              cap_dir;

  logic              eff_rev;
  logic [ROT_W-1:0]  eff_rot;
  logic              eff_dir;
  logic              completing;
  logic              accept;
  logic              done;
  logic [CNT_W-1:0]  pos;
  logic [DATA_W-1:0] placed;
  logic [ROT_MAX_W-1:0] rot_in;
  logic [ROT_MAX_W-1:0] rot_out;
  logic [DATA_W-1:0] word_fin;
  logic              word_short;

  // Chunk 0 uses the live config so the very first slice is placed correctly;
  // later chunks use the copy captured with it.
  assign eff_rev = (count == '0) ? cfg_rev : cap_rev;
  assign eff_rot = (count == '0) ? cfg_rot : cap_rot;
  assign eff_dir = (count == '0) ? cfg_dir : cap_dir;

  assign completing = (count == LAST_CNT) || in_last;

  // Only a word-completing chunk needs the output register to have room.
  assign in_ready = !(completing && out_valid && !out_ready);
  assign accept   = in_valid && in_ready;
  assign done     = accept && completing;

  // Slice index: forward order fills from the MSB slice down.
  assign pos = eff_rev ? count : (LAST_CNT - count);

  always_comb begin
    placed = asm_q;
    for (int k = 0; k < NCH; k++) begin
      if (CNT_W'(k) == pos) placed[k*SLICE_W +: SLICE_W] = in_data;
    end
  end

  assign rot_in   = ROT_MAX_W'(placed);
  assign rot_out  = rot_undo(rot_in, 32'(eff_rot), eff_dir, DATA_W);
  assign word_fin = rot_out[DATA_W-1:0];

  // in_last on the final chunk is an ordinary completion.
  assign word_short = in_last && (count != LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      asm_q   <= '0;
      cap_rev <= 1'b0;
      cap_rot <= '0;
      cap_dir <= 1'b0;
    end else if (accept) begin
      if (count == '0) begin
        cap_rev <= cfg_rev;
        cap_rot <= cfg_rot;
        cap_dir <= cfg_dir;
      end
      if (completing) begin
        count <= '0;
        asm_q <= '0;
      end else begin
        count <= count + CNT_W'(1);
        asm_q <= placed;
      end
    end
  end

  stream_out_reg #(
    .DATA_W(DATA_W)
  ) u_out (
    .clk       (clk),
    .rst       (rst),
    .load      (done),
    .load_data (word_fin),
    .load_short(word_short),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_short (out_short)
  );

endmodule

// File: tb/tb_stream_unpacker.sv
module tb_stream_unpacker;

  localparam int DW = 4;
  localparam int SW = 2;
  localparam int NC = DW / SW;
  localparam int RW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] in_data;
  logic          in_last;
  logic          cfg_rev;
  logic [RW-1:0] cfg_rot;
  logic          cfg_dir;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_short;

  int total = 0;
  int bad   = 0;

  stream_unpacker #(.DATA_W(DW), .SLICE_W(SW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .cfg_rev  (cfg_rev),
    .cfg_rot  (cfg_rot),
    .cfg_dir  (cfg_dir),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_short(out_short)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct {
    logic [DW-1:0] d;
    logic          s;
  } exp_t;

  exp_t          q[$];
  int            m_cnt;
  logic [SW-1:0] m_ch [NC];
  logic          m_rev;
  logic [RW-1:0] m_rot;
  logic          m_dir;

  // Build the expected word from the first n chunks, then undo the rotation
  // by shifting a doubled copy of the word.
  function automatic logic [DW-1:0] build(input int n);
    logic [DW-1:0]   w;
    logic [2*DW-1:0] dbl;
    logic [2*DW-1:0] sh;
    int              a;
    w = '0;
    for (int k = 0; k < n; k++) begin
      if (m_rev) w = w | (DW'(m_ch[k]) << (k * SW));
      else       w = w | (DW'(m_ch[k]) << (DW - (k + 1) * SW));
    end
    a   = int'(m_rot) % DW;
    dbl = {w, w};
    if (!m_dir) begin
      sh = dbl >> a;
      return sh[DW-1:0];
    end
    sh = dbl << a;
    return sh[2*DW-1:DW];
  endfunction

  always @(negedge clk) begin
    logic comp;
    logic exp_rdy;
    exp_t e;
    if (rst) begin
      q.delete();
      m_cnt = 0;
      check("rst_out_valid", out_valid, 0);
    end else begin
      comp    = (m_cnt == NC - 1) || in_last;
      exp_rdy = !(comp && (q.size() > 0) && !out_ready);
      check("in_ready", in_ready, exp_rdy);
      check("out_valid", out_valid, q.size() > 0);
      if (q.size() > 0) begin
        check("out_data", out_data, q[0].d);
        check("out_short", out_short, q[0].s);
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && exp_rdy) begin
        if (m_cnt == 0) begin
          m_rev = cfg_rev;
          m_rot = cfg_rot;
          m_dir = cfg_dir;
          for (int k = 0; k < NC; k++) m_ch[k] = '0;
        end
        m_ch[m_cnt] = in_data;
        if (comp) begin
          e.d = build(m_cnt + 1);
          e.s = in_last && (m_cnt != NC - 1);
          q.push_back(e);
          m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic send(input logic [SW-1:0] d, input logic last);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    if (!in_ready) check("send_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [DW-1:0] d, input logic s);
    @(negedge clk);
    check({name, "_valid"}, out_valid, 1);
    check({name, "_data"}, out_data, d);
    check({name, "_short"}, out_short, s);
  endtask

  task automatic set_cfg(input logic rev, input logic [RW-1:0] rot, input logic dir);
    cfg_rev = rev;
    cfg_rot = rot;
    cfg_dir = dir;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    set_cfg(0, 0, 0);
    #2;
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_out_short", out_short, 0);
    check("reset_in_ready", in_ready, 1);
    idle(2);
    rst = 1'b0;
    idle(1);

    // Forward order, no rotation.
    set_cfg(0, 0, 0);
    send(2'b10, 0);
    send(2'b01, 0);
    expect_out("fwd", 4'b1001, 0);
    idle(2);

    // Reversed slice order.
    set_cfg(1, 0, 0);
    send(2'b10, 0);
    send(2'b01, 0);
    expect_out("rev", 4'b0110, 0);
    idle(2);

    // Undo left rotate by 1 (rotate right).
    set_cfg(0, 1, 0);
    send(2'b10, 0);
    send(2'b01, 0);
    expect_out("rot_r", 4'b1100, 0);
    idle(2);

    // Undo right rotate by 1 (rotate left).
    set_cfg(0, 1, 1);
    send(2'b10, 0);
    send(2'b01, 0);
    expect_out("rot_l", 4'b0011, 0);
    idle(2);

    // Short word terminated on chunk 0.
    set_cfg(0, 0, 0);
    send(2'b11, 1);
    expect_out("short", 4'b1100, 1);
    idle(2);

    // Stall: word A held, word B's completing chunk must wait.
    out_ready = 1'b0;
    send(2'b10, 0);
    send(2'b01, 0);
    send(2'b11, 0);
    in_valid = 1'b1;
    in_data  = 2'b00;
    @(negedge clk);
    check("stall_in_ready", in_ready, 0);
    check("stall_data", out_data, 4'b1001);
    @(negedge clk);
    check("stall_data_hold", out_data, 4'b1001);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    expect_out("b2b", 4'b1100, 0);
    idle(2);

    // Reset mid-word with a held output word.
    out_ready = 1'b0;
    send(2'b10, 0);
    send(2'b01, 0);
    send(2'b11, 0);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    send(2'b01, 0);
    send(2'b10, 0);
    expect_out("after_rst", 4'b0110, 0);
    idle(2);

    // Randomized traffic checked against the model.
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      rst       = ($urandom_range(0, 499) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = SW'($urandom);
      in_last   = ($urandom_range(0, 99) < 15);
      out_ready = ($urandom_range(0, 9) < 6);
      set_cfg(1'($urandom), RW'($urandom), 1'($urandom));
    end
    @(posedge clk);
    #1;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
